// File: rtl/i2s_rx_frame_ctrl.sv
// i2s_rx_frame_ctrl: master-mode I2S frame timing plus left/right pairing with a valid/ready output
module i2s_rx_frame_ctrl #(
    parameter int BITS_PER_CH = 32,
    parameter int WIDTH       = 24
) (
    input  logic             sclk,
    input  logic             rst,
    input  logic             enable,
    input  logic             overrun_clr,
    output logic             lrclk,
    input  logic [WIDTH-1:0] rx_data,
    input  logic             rx_dvalid,
    output logic [WIDTH-1:0] left_out,
    output logic [WIDTH-1:0] right_out,
    output logic             pair_valid,
    input  logic             pair_ready,
    output logic             overrun,
    output logic [15:0]      frame_cnt
);
    localparam int FRAME = 2 * BITS_PER_CH;
    localparam int CW = $clog2(FRAME);
    localparam logic [CW-1:0] LAST = CW'(FRAME - 1);
    localparam logic [CW-1:0] HALF = CW'(BITS_PER_CH);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             lrclk_q, lrclk_d;
    logic             dvalid_q;
    logic             left_held_q, left_held_d;
    logic [WIDTH-1:0] left_hold_q, left_hold_d;
    logic [WIDTH-1:0] left_out_q, left_out_d;
    logic [WIDTH-1:0] right_out_q, right_out_d;
    logic             pair_valid_q, pair_valid_d;
    logic             overrun_q, overrun_d;
    logic [15:0]      frame_cnt_q, frame_cnt_d;
    logic             active, rise, cap_l, cap_r, slot_free, load, drop, take;

    // Frame counter, channel pairing, output slot and overrun bookkeeping
    always_comb begin
        active       = (state_q == RUN) & enable;
        rise         = rx_dvalid & ~dvalid_q;
        state_d      = enable ? RUN : IDLE;
        cnt_d        = active ? ((cnt_q == LAST) ? '0 : cnt_q + CW'(1)) : '0;
        lrclk_d      = active & (cnt_d >= HALF);
        cap_l        = active & rise & ~lrclk_q;
        cap_r        = active & rise & lrclk_q & left_held_q;
        take         = pair_valid_q & pair_ready;
        slot_free    = ~pair_valid_q | pair_ready;
        load         = cap_r & slot_free;
        drop         = cap_r & ~slot_free;
        left_held_d  = active & (cap_l | (left_held_q & ~(rise & lrclk_q)));
        left_hold_d  = cap_l ? rx_data : left_hold_q;
        left_out_d   = load ? left_hold_q : left_out_q;
        right_out_d  = load ? rx_data : right_out_q;
        pair_valid_d = load | (pair_valid_q & ~pair_ready);
        overrun_d    = drop | (overrun_q & ~overrun_clr);
        frame_cnt_d  = frame_cnt_q + 16'(take);
    end

    // State registers; reset overrides everything, dropping any pending pair
    always_ff @(posedge sclk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            lrclk_q      <= 1'b0;
            dvalid_q     <= 1'b0;
            left_held_q  <= 1'b0;
            left_hold_q  <= '0;
            left_out_q   <= '0;
            right_out_q  <= '0;
            pair_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
            frame_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            lrclk_q      <= lrclk_d;
            dvalid_q     <= rx_dvalid;
            left_held_q  <= left_held_d;
            left_hold_q  <= left_hold_d;
            left_out_q   <= left_out_d;
            right_out_q  <= right_out_d;
            pair_valid_q <= pair_valid_d;
            overrun_q    <= overrun_d;
            frame_cnt_q  <= frame_cnt_d;
        end
    end

    assign lrclk      = lrclk_q;
    assign left_out   = left_out_q;
    assign right_out  = right_out_q;
    assign pair_valid = pair_valid_q;
    assign overrun    = overrun_q;
    assign frame_cnt  = frame_cnt_q;
endmodule
